// File: rtl/bram_arbiter.sv
// Two-requester arbiter for a single-port synchronous-read BRAM.
// Round-robin on ties, optional lock ownership with a bounded burst while the other side waits.
module bram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_lock0,
    input  logic                  i_lock1,
    input  logic                  i_write0,
    input  logic                  i_write1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic                  o_bram_write,
    output logic [DATA_WIDTH-1:0] o_bram_data,
    input  logic [DATA_WIDTH-1:0] i_bram_data
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    state_t                state;
    logic                  ptr;        // last granted requester
    logic [7:0]            cnt;
    logic [7:0]            cnt_inc;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  own_req;
    logic                  own_lock;
    logic                  other_req;

    // Grants are gated by reset so nothing is accepted while the arbiter is held.
    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_rst) begin
            case (state)
                IDLE: begin
                    if (i_req0 && (!i_req1 || ptr)) o_gnt0 = 1'b1;
                    else if (i_req1)                o_gnt1 = 1'b1;
                end
                OWN0:    o_gnt0 = i_req0;
                OWN1:    o_gnt1 = i_req1;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_bram_write = (o_gnt0 && i_write0) || (o_gnt1 && i_write1);
        if (o_gnt0) begin
            o_bram_addr = i_addr0;
            o_bram_data = i_wdata0;
        end else if (o_gnt1) begin
            o_bram_addr = i_addr1;
            o_bram_data = i_wdata1;
        end else begin
            o_bram_addr = addr_q;
            o_bram_data = data_q;
        end
    end

    assign o_rdata   = i_bram_data;
    assign own_req   = (state == OWN1) ? i_req1  : i_req0;
    assign own_lock  = (state == OWN1) ? i_lock1 : i_lock0;
    assign other_req = (state == OWN1) ? i_req0  : i_req1;
    assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= IDLE;
            ptr       <= 1'b1;
            cnt       <= 8'd0;
            addr_q    <= '0;
            data_q    <= '0;
            o_rvalid0 <= 1'b0;
            o_rvalid1 <= 1'b0;
        end else begin
            o_rvalid0 <= o_gnt0 && !i_write0;
            o_rvalid1 <= o_gnt1 && !i_write1;
            if (o_gnt0 || o_gnt1) begin
                ptr    <= o_gnt1;
                addr_q <= o_bram_addr;
                data_q <= o_bram_data;
            end
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (o_gnt0 && i_lock0)      state <= OWN0;
                    else if (o_gnt1 && i_lock1) state <= OWN1;
                end
                OWN0, OWN1: begin
                    if (own_req) begin
                        // Hitting the burst limit drops to IDLE with ptr = owner,
                        // so the waiting side wins the very next cycle.
                        if (!own_lock || (other_req && cnt_inc >= BURST_LIM)) begin
                            state <= IDLE;
                            cnt   <= 8'd0;
                        end else begin
                            cnt <= other_req ? cnt_inc : 8'd0;
                        end
                    end else begin
                        cnt <= 8'd0;
                        if (other_req) state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end
endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
Two-requester arbiter for the single-port on-chip BRAM. It shares the BRAM between the CPU memory path (requester 0) and a second master, such as the UART loader or DMA (requester 1). It accepts per-requester request/grant transactions and drives the BRAM port from the granted requester. It returns synchronous-read data to the owner with a valid strobe, enforcing round-robin fairness and a bounded lock (burst) length. It sits between memmap/loader and the bram instance in LEG.

Parameters:
DATA_WIDTH, 32, width of BRAM data words.
ADDR_WIDTH, 10, BRAM word address width.
MAX_BURST, 8, max consecutive grants to a locking requester while the other requester is waiting (1..255).

Ports:
i_clk  input  1  system clock, all state on rising edge.
i_rst  input  1  asynchronous active-low reset.
i_req0 / i_req1  input  1  request from requester 0 / 1.
i_lock0 / i_lock1  input  1  requester wants to keep ownership after this access.
i_write0 / i_write1  input  1  1 = write, 0 = read.
i_addr0 / i_addr1  input  ADDR_WIDTH  word address.
i_wdata0 / i_wdata1  input  DATA_WIDTH  write data.
o_gnt0 / o_gnt1  output  1  access accepted this cycle (combinational).
o_rvalid0 / o_rvalid1  output  1  read data valid on o_rdata for that requester.
o_rdata  output  DATA_WIDTH  read data (shared bus, qualified by rvalid).
o_bram_addr  output  ADDR_WIDTH  to BRAM i_addr.
o_bram_write  output  1  to BRAM i_write.
o_bram_data  output  DATA_WIDTH  to BRAM i_data.
i_bram_data  input  DATA_WIDTH  from BRAM o_data (1-cycle synchronous read).

Behaviour:
- Reset (i_rst low, asynchronous): gnt0/1=0, rvalid0/1=0, o_bram_write=0, o_bram_addr=0, o_bram_data=0, last-grant pointer=1 (so requester 0 wins first tie), owner=none, burst counter=0. Reset mid-read drops the pending rvalid.
- Handshake: requester holds req/write/addr/wdata stable until it sees gnt high in a cycle; gnt=1 means accepted at that rising edge. At most one gnt per cycle.
- Transfer: BRAM inputs are a combinational mux of the granted requester. With no grant, o_bram_write=0, addr/data hold the last granted values. Write completes at the grant edge.
- Read latency: gnt on read at cycle N -> rvalidX=1 and o_rdata=i_bram_data in cycle N+1, for exactly one cycle. Back-to-back reads give a continuous rvalid stream.
- Arbitration states: IDLE (no owner), OWN0, OWN1.
  - IDLE: one request -> grant it. Both requesting -> grant the requester not in the last-grant pointer. The next state is OWNx if lockX was set with the granted access, else IDLE.
  - OWNx: only x may be granted. A grant with lockX=1 stays in OWNx. A grant with lockX=0 returns to IDLE. reqX=0 with the other requester waiting returns to IDLE (no grant issued that cycle). reqX=0 with nobody waiting stays in OWNx.
- Burst limit: the counter increments on each grant to the owner while the other req is high, and clears when the other req is low or on leaving OWNx. When the counter reaches MAX_BURST, the next cycle forces IDLE with the pointer = owner, so the waiting requester wins.
- The last-grant pointer updates on every grant.
- Widths: counter is 8 bits, saturating. Addresses pass through unmodified, with no range checking (memmap owns invalid_addr).
- Simultaneous events: a request withdrawn in the same cycle that the other requester asserts is resolved by the current state only. rvalid for an earlier read is still delivered even if ownership changes.

Test Plan:
1. Reset: hold i_rst=0 with req0=req1=1 -> all gnt/rvalid=0, o_bram_write=0. Release -> first gnt goes to requester 0.
2. Single read: req0 read addr 0x005, BRAM preloaded 0xDEADBEEF -> gnt0 in cycle 0, rvalid0=1 and o_rdata=0xDEADBEEF in cycle 1 only, rvalid1=0.
3. Round-robin: req0 and req1 held high, no lock, 6 cycles -> grants alternate 0,1,0,1,0,1.
4. Write/read-back: req1 writes 0x12345678 to addr 0x3FF, then reads 0x3FF -> o_bram_write=1 only in the write-grant cycle; rvalid1 with 0x12345678 in the cycle after the read grant. Addr wrap is not altered.
5. Burst limit: MAX_BURST=4, req0+lock0 continuous, req1 asserted from cycle 2 -> exactly 4 grants to 0 after req1 rises, then gnt1 on the following cycle.
6. Reset mid-read: gnt0 read at cycle N, i_rst low at N+0.5 -> rvalid0 stays 0. After release, the state is IDLE and the pointer favours requester 0.
